// File: rtl/vote_pkg.sv
// Shared definitions for the vote logger: candidate count, tally width default,
// FSM state type, saturation limit and a helper that counts coincident press events.
package vote_pkg;

    localparam int NUM_CAND  = 4;
    localparam int CNT_W_DEF = 8;
    localparam int PCNT_W    = $clog2(NUM_CAND + 1);

    // Saturation limit of a default-width tally; modules with other widths derive their own.
    localparam logic [CNT_W_DEF-1:0] TALLY_MAX = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        LOCKOUT = 1'b1
    } state_t;

    function automatic logic [PCNT_W-1:0] count_presses(input logic [NUM_CAND-1:0] v);
        logic [PCNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            n = n + {{(PCNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One candidate button: 2-flop synchroniser, consecutive-sample debouncer and rising-edge detect.
// o_press is a single-cycle pulse, DEBOUNCE_CYC+1 edges after the raw level first stays stable.
module button_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= 2'b00;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            // Any sample agreeing with the current level restarts the stability count.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

    assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/vote_logger.sv
// Button conditioning, one-vote-per-press FSM with lockout, and saturating per-candidate tallies.
// Optional macro VOTE_LOGGER_CLEAR_EN adds clear_votes (zeroes tallies in result mode).
module vote_logger
    import vote_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEBOUNCE_CYC = 4,
    parameter int LOCKOUT_CYC  = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
`ifdef VOTE_LOGGER_CLEAR_EN
    input  logic             clear_votes,
`endif
    input  logic             button1,
    input  logic             button2,
    input  logic             button3,
    input  logic             button4,
    output logic [CNT_W-1:0] candidate1_vote,
    output logic [CNT_W-1:0] candidate2_vote,
    output logic [CNT_W-1:0] candidate3_vote,
    output logic [CNT_W-1:0] candidate4_vote,
    output logic             valid_vote_casted,
    output logic             invalid_press,
    output logic             busy
);

    localparam int                LW      = $clog2(LOCKOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  SAT_MAX = '1;

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [NUM_CAND-1:0] w_btn;
    logic [NUM_CAND-1:0] w_press;
    logic [PCNT_W-1:0]   w_npress;
    logic                w_clear;

    state_t              r_state;
    logic [LW-1:0]       r_lock_cnt;
    logic [CNT_W-1:0]    r_tally [NUM_CAND];
    logic                r_valid;
    logic                r_invalid;
    logic                r_busy;

    // Assert asynchronously, release two edges after reset rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_btn = {button4, button3, button2, button1};

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .i_clk  (clock),
            .i_rst_n(w_rst_n),
            .i_btn  (w_btn[g]),
            .o_press(w_press[g])
        );
    end

    assign w_npress = count_presses(w_press);

`ifdef VOTE_LOGGER_CLEAR_EN
    assign w_clear = mode & clear_votes;
`else
    assign w_clear = 1'b0;
`endif

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_valid    <= 1'b0;
            r_invalid  <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                r_tally[i] <= '0;
            end
        end else begin
            r_valid   <= 1'b0;
            r_invalid <= 1'b0;

            if (w_clear) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    r_tally[i] <= '0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (!mode) begin
                        if (w_npress == PCNT_W'(1)) begin
                            // A saturated tally still acknowledges the vote.
                            for (int i = 0; i < NUM_CAND; i++) begin
                                if (w_press[i] && (r_tally[i] != SAT_MAX)) begin
                                    r_tally[i] <= r_tally[i] + CNT_W'(1);
                                end
                            end
                            r_valid    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_lock_cnt <= LW'(LOCKOUT_CYC);
                            r_state    <= LOCKOUT;
                        end else if (w_npress > PCNT_W'(1)) begin
                            r_invalid <= 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (mode || (r_lock_cnt == LW'(1))) begin
                        r_lock_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - LW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign candidate1_vote   = r_tally[0];
    assign candidate2_vote   = r_tally[1];
    assign candidate3_vote   = r_tally[2];
    assign candidate4_vote   = r_tally[3];
    assign valid_vote_casted = r_valid;
    assign invalid_press     = r_invalid;
    assign busy              = r_busy;

endmodule

// File: doc/vote_logger.md
Name: vote_logger

Overview:
- Upstream stage of the voting machine's mode/LED controller.
- Conditions four raw candidate buttons: synchronise, debounce, rising-edge detect.
- In voting mode, accepts one vote per press and keeps one saturating tally per candidate.
- Emits a one-cycle valid_vote_casted pulse that the LED controller uses to start its display counter.

Parameters:
- CNT_W, 8: width of each candidate tally.
- DEBOUNCE_CYC, 4: consecutive stable synchronised samples required before the debounced level changes (min 1).
- LOCKOUT_CYC, 10: cycles after an accepted vote during which all press events are discarded (min 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = voting, 1 = result; already synchronous to clock.
- button1 .. button4  in  1 each  raw, asynchronous, bouncing candidate buttons.
- candidate1_vote .. candidate4_vote  out  CNT_W each  registered tallies.
- valid_vote_casted  out  1  one-cycle pulse on each accepted vote.
- invalid_press  out  1  one-cycle pulse when two or more press events coincide in IDLE voting mode.
- busy  out  1  high while in LOCKOUT.

Behaviour:
- Reset (reset low, async):
  - all tallies 0, valid_vote_casted 0, invalid_press 0, busy 0;
  - synchronisers, debounced levels and debounce counters 0;
  - FSM enters IDLE.
- Reset deassertion is synchronised internally; first functional edge is the one after release.
- Per-button conditioning:
  - 2-flop synchroniser feeds the debouncer.
  - Debouncer counts consecutive edges where the synchroniser output differs from the debounced level.
  - Counter clears on any edge where they match.
  - The debounced level flips on the edge the count reaches DEBOUNCE_CYC.
  - Press event = debounced high and previous debounced low; lasts exactly one cycle.
  - A button must debounce low before it can generate another event.
- Latency: raw button goes high and stays stable, first sampled at edge 0 → tally and valid_vote_casted updated at edge DEBOUNCE_CYC+2.
- FSM IDLE:
  - mode=0, exactly one press event: increment that tally, pulse valid_vote_casted, load lockout counter with LOCKOUT_CYC, go LOCKOUT.
  - mode=0, two or more events on the same cycle: pulse invalid_press; no tally change; stay IDLE.
  - mode=1: events ignored, no pulses.
- FSM LOCKOUT:
  - busy=1; all press events discarded, never queued.
  - Counter decrements each cycle; on reaching 0, return to IDLE.
  - LOCKOUT lasts exactly LOCKOUT_CYC cycles.
  - mode going to 1 aborts to IDLE on the next edge, clearing busy.
- Tally saturation: a tally at 2^CNT_W-1 stays there; valid_vote_casted still pulses (the vote is acknowledged).
- Tallies hold across mode changes; only reset (or the optional clear) zeroes them.
- Asserting reset mid-lockout or mid-debounce zeroes everything immediately.

Optional Feature:
- Macro VOTE_LOGGER_CLEAR_EN.
- Defined:
  - adds input clear_votes (1 bit);
  - when clear_votes=1 and mode=1, all tallies zero on the next edge;
  - clear_votes is ignored when mode=0.
- Undefined: port absent; tallies cleared only by reset.

Decomposition:
- Package vote_pkg holds:
  - NUM_CAND=4 and default CNT_W=8;
  - state typedef {IDLE, LOCKOUT};
  - the saturating-max constant.
- Sub-module button_debounce (synchroniser + debouncer + edge detect, parameter DEBOUNCE_CYC), instanced four times.
- FSM, lockout counter and tallies live in vote_logger.

Test Plan:
- Reset low mid-run → all tallies 0, busy 0, pulses 0 asynchronously; first edge after release is functional.
- Mode 0; button2 held stable from edge 0 → at edge 6 (DEBOUNCE_CYC=4) candidate2_vote 0→1 and valid_vote_casted high for 1 cycle; busy high for exactly 10 cycles.
- Button1 bounces 1-0-1 every 2 cycles, then holds high → exactly one vote.
- Button3 re-pressed during lockout → no count.
- Button1 and button4 events on the same cycle → invalid_press one cycle; tallies unchanged.
- Mode 1 with presses → no count and no pulses.
- Mode set to 1 mid-lockout → busy drops at the next edge.
- Preload candidate4 to 255 via 255 presses, press again → stays 255 and valid_vote_casted pulses.
- With VOTE_LOGGER_CLEAR_EN: clear_votes in mode 1 zeroes tallies; in mode 0 it has no effect.
